// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode/stat constants and memory-stage FSM states
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_mem_write(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == IPUSHQ) || (ic == ICALL);
    endfunction

    function automatic logic is_mem_read(input logic [3:0] ic);
        return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
    endfunction

endpackage

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 memory stage: fault screening, one req/ack data access, valM and stat
module memory_stage
    import y86_pkg::*;
#(
    parameter int DMEM_BYTES  = 1024,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic [63:0] valM,
    output logic        done,
    output logic        busy,
    output logic [2:0]  stat
);

    localparam int          CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [63:0] ADDR_MAX = 64'(DMEM_BYTES - 8);

    mem_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  stat_q, stat_d;
    logic [63:0] val_m_q, val_m_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;

    logic        acc_rd, acc_wr;
    logic [63:0] acc_addr, acc_wdata;

    always_comb begin
        acc_rd    = is_mem_read(icode);
        acc_wr    = is_mem_write(icode);
        // ret/popq read through the old stack pointer, everything else through valE
        acc_addr  = (icode == IRET || icode == IPOPQ) ? valA : valE;
        acc_wdata = (icode == ICALL) ? valP : valA;

        state_d = state_q;
        cnt_d   = cnt_q;
        stat_d  = stat_q;
        val_m_d = val_m_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start && stat_q == STAT_AOK) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (imem_error) begin
                        stat_d = STAT_ADR;
                    end else if (!instr_valid) begin
                        stat_d = STAT_INS;
                    end else if (icode == IHALT) begin
                        stat_d = STAT_HLT;
                    end else if (acc_rd || acc_wr) begin
                        if (acc_addr > ADDR_MAX) begin
                            stat_d = STAT_ADR;
                        end else begin
                            we_d    = acc_wr;
                            addr_d  = acc_addr;
                            wdata_d = acc_wdata;
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        val_m_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    stat_d  = STAT_ADR;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stat_q  <= STAT_AOK;
            val_m_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stat_q  <= stat_d;
            val_m_q <= val_m_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // req comes straight from the state flop so an async reset kills it immediately
    assign mem_req   = (state_q == S_REQ);
    assign busy      = (state_q == S_REQ);
    assign done      = (state_q == S_DONE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign valM      = val_m_q;
    assign stat      = stat_q;

endmodule
